sram_1rw_masked_init: RTL and testbench

- Parametrised single-port (1RW) synchronous SRAM model; successor to the fixed 1024x82 unmasked array models.
- Adds write masking by segment, a hardware clear-on-reset sweep, valid/ready request handshake, response valid and read-data hold.
- Sits between cache/predictor table logic and the memory array; drop-in for generated array wrappers in simulation and FPGA builds.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_clear_ctrl.sv | 53 +++++
 rtl/sram_1rw_masked_init.sv | 109 ++++++++++
 tb/tb_sram_1rw_masked_init.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared state encoding, address-width helper and read latency for the masked-init SRAM.
// SRAM_OUTREG_EN selects the two-stage (latency 2) read pipeline.
package sram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

`ifdef SRAM_OUTREG_EN
  localparam int READ_LAT = 2;
`else
  localparam int READ_LAT = 1;
`endif

  // Address width never drops below one bit so a single-entry array still has a port.
  function automatic int sram_clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// Post-reset clear sweep: walks every entry once writing zero, then parks in READY.
module sram_clear_ctrl
  import sram_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = sram_clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  sram_state_e       r_state;
  sram_state_e       w_stateNext;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cntNext;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    clr_we      = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        w_cntNext = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_stateNext = ST_READY;
          w_cntNext   = '0;
        end
      end
      ST_READY: w_stateNext = ST_READY;
      default:  w_stateNext = ST_CLEAR;
    endcase
  end

  assign clr_addr  = r_cnt;
  assign init_done = (r_state == ST_READY);

endmodule

// File: rtl/sram_1rw_masked_init.sv
// Single-port SRAM model with per-segment write mask, clear-on-reset sweep and held read data.
// Defining SRAM_OUTREG_EN adds an output register stage (read latency 2).
module sram_1rw_masked_init
  import sram_pkg::*;
#(
  parameter  int DEPTH    = 1024,
  parameter  int WIDTH    = 82,
  parameter  int MASK_SEG = 41,
  localparam int ADDR_W   = sram_clog2(DEPTH),
  localparam int MASK_W   = WIDTH / MASK_SEG
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wmode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              init_done
);

  if (WIDTH % MASK_SEG != 0) begin : g_badMaskSeg
    $error("sram_1rw_masked_init: WIDTH must be a multiple of MASK_SEG");
  end

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_clrWe;
  logic [ADDR_W-1:0] w_clrAddr;
  logic              w_initDone;
  logic              w_accept;
  logic              w_inRange;
  logic              w_wrEn;
  logic              w_rdEn;
  logic              r_rdValid;
  logic [WIDTH-1:0]  r_rdData;

  sram_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clearCtrl (
    .clock     (clock),
    .reset     (reset),
    .clr_we    (w_clrWe),
    .clr_addr  (w_clrAddr),
    .init_done (w_initDone)
  );

  // Requests arriving in the reset cycle are ignored even though the FSM still shows READY.
  assign w_accept   = req_valid && w_initDone && !reset;
  assign w_inRange  = ({1'b0, req_addr} < DEPTH_EXT);
  assign w_wrEn     = w_accept && req_wmode && w_inRange;
  assign w_rdEn     = w_accept && !req_wmode;
  assign req_ready  = w_initDone;
  assign init_done  = w_initDone;

  always_ff @(posedge clock) begin
    if (w_clrWe) begin
      r_mem[w_clrAddr] <= '0;
    end else if (w_wrEn) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (req_wmask[i]) begin
          r_mem[req_addr][i*MASK_SEG +: MASK_SEG] <= req_wdata[i*MASK_SEG +: MASK_SEG];
        end
      end
    end
  end

  // First read stage; data only moves on a read so the last value is held otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
    end else begin
      r_rdValid <= w_rdEn;
      if (w_rdEn) begin
        r_rdData <= w_inRange ? r_mem[req_addr] : '0;
      end
    end
  end

`ifdef SRAM_OUTREG_EN
  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      r_outValid <= r_rdValid;
      if (r_rdValid) begin
        r_outData <= r_rdData;
      end
    end
  end

  assign resp_valid = r_outValid;
  assign resp_rdata = r_outData;
`else
  assign resp_valid = r_rdValid;
  assign resp_rdata = r_rdData;
`endif

endmodule

// File: tb/tb_sram_1rw_masked_init.sv
// Directed bench for sram_1rw_masked_init: a 1024-deep and a 1000-deep instance share one stimulus stream.
module tb_sram_1rw_masked_init;

`ifdef SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [81:0] ONES       = '1;
  localparam logic [81:0] UPPER_ONLY = {{41{1'b1}}, {41{1'b0}}};
  localparam logic [81:0] DATA_A     = 82'h2_1234_5678_9ABC_DEF0_1357;
  localparam logic [81:0] DATA_B     = 82'h1_0F0F_0F0F_F0F0_F0F0_AAAA;
  localparam logic [81:0] DATA_C     = 82'h3_0000_1111_2222_3333_4444;

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqWmode = 1'b0;
  logic [9:0]  reqAddr  = '0;
  logic [81:0] reqWdata = '0;
  logic [1:0]  reqWmask = '0;

  logic        readyA, respValidA, initA;
  logic [81:0] rdataA;
  logic        readyB, respValidB, initB;
  logic [81:0] rdataB;

  int checks = 0;
  int errors = 0;

  logic        b2bWm   [5];
  logic [9:0]  b2bAddr [5];
  logic [81:0] b2bData [5];

  always #5 clock = ~clock;

  sram_1rw_masked_init #(.DEPTH(1024), .WIDTH(82), .MASK_SEG(41)) dutA (
    .clock(clock), .reset(reset), .req_valid(reqValid), .req_ready(readyA),
    .req_wmode(reqWmode), .req_addr(reqAddr), .req_wdata(reqWdata), .req_wmask(reqWmask),
    .resp_valid(respValidA), .resp_rdata(rdataA), .init_done(initA)
  );

  sram_1rw_masked_init #(.DEPTH(1000), .WIDTH(82), .MASK_SEG(41)) dutB (
    .clock(clock), .reset(reset), .req_valid(reqValid), .req_ready(readyB),
    .req_wmode(reqWmode), .req_addr(reqAddr), .req_wdata(reqWdata), .req_wmask(reqWmask),
    .resp_valid(respValidB), .resp_rdata(rdataB), .init_done(initB)
  );

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wmode, input logic [9:0] addr, input logic [81:0] data,
                               input logic [1:0] mask);
    reqValid = 1'b1;
    reqWmode = wmode;
    reqAddr  = addr;
    reqWdata = data;
    reqWmask = mask;
  endtask

  task automatic idle();
    reqValid = 1'b0;
    reqWmode = 1'b0;
    reqAddr  = '0;
    reqWdata = '0;
    reqWmask = '0;
  endtask

  task automatic doWrite(input logic [9:0] addr, input logic [81:0] data, input logic [1:0] mask);
    applyStimulus(1'b1, addr, data, mask);
    @(negedge clock);
    idle();
  endtask

  // Returns on the negedge where the response for this read must be visible.
  task automatic doRead(input string tag, input logic [9:0] addr, input logic [81:0] expA,
                        input bit checkB, input logic [81:0] expB);
    applyStimulus(1'b0, addr, '0, '0);
    @(negedge clock);
    idle();
    repeat (LAT - 1) @(negedge clock);
    checkOutput({tag, ".validA"}, 128'(respValidA), 128'd1);
    checkOutput({tag, ".dataA"}, 128'(rdataA), 128'(expA));
    if (checkB) begin
      checkOutput({tag, ".validB"}, 128'(respValidB), 128'd1);
      checkOutput({tag, ".dataB"}, 128'(rdataB), 128'(expB));
    end
  endtask

  // Releases reset and counts cycles until each instance reports init_done.
  task automatic waitInit(input string tag, input bit pokeDuringSweep);
    int cyc       = 0;
    int cycB      = 0;
    int respSeen  = 0;
    reset = 1'b0;
    while (!initA && cyc < 3000) begin
      if (pokeDuringSweep && cyc < 900) applyStimulus(cyc[0], 10'd9, ONES, 2'b11);
      else idle();
      @(negedge clock);
      cyc++;
      if (respValidA || respValidB) respSeen++;
      if (initB && cycB == 0) cycB = cyc;
    end
    idle();
    checkOutput({tag, ".cyclesA"}, 128'(cyc), 128'd1024);
    checkOutput({tag, ".cyclesB"}, 128'(cycB), 128'd1000);
    checkOutput({tag, ".readyA"}, 128'(readyA), 128'd1);
    checkOutput({tag, ".readyB"}, 128'(readyB), 128'd1);
    checkOutput({tag, ".respDuringSweep"}, 128'(respSeen), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    b2bWm   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    b2bAddr = '{10'd7, 10'd7, 10'd7, 10'd7, 10'd2};
    b2bData = '{DATA_A, 82'd0, DATA_B, 82'd0, 82'd0};
    idle();
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst.ready", 128'(readyA), 128'd0);
    checkOutput("rst.valid", 128'(respValidA), 128'd0);
    checkOutput("rst.rdata", 128'(rdataA), 128'd0);
    checkOutput("rst.init", 128'(initA), 128'd0);

    waitInit("init1", 1'b1);
    doRead("rd0", 10'd0, '0, 1'b1, '0);
    doRead("rd5", 10'd5, '0, 1'b1, '0);
    doRead("rd1023", 10'd1023, '0, 1'b1, '0);
    doRead("rd9", 10'd9, '0, 1'b1, '0);

    doWrite(10'd3, ONES, 2'b11);
    doRead("full3", 10'd3, ONES, 1'b1, ONES);
    doWrite(10'd3, '0, 2'b01);
    doRead("part01", 10'd3, UPPER_ONLY, 1'b1, UPPER_ONLY);
    doWrite(10'd3, ONES, 2'b00);
    doRead("mask00", 10'd3, UPPER_ONLY, 1'b1, UPPER_ONLY);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("hold.valid", 128'(respValidA), 128'd0);
      checkOutput("hold.data", 128'(rdataA), 128'(UPPER_ONLY));
    end

    // Requests on five consecutive cycles; reads 1, 3 and 4 answer LAT cycles later.
    for (int c = 0; c <= 5 + LAT; c++) begin
      int k;
      logic expValid;
      logic [81:0] expData;
      k        = c - LAT;
      expValid = (k == 1) || (k == 3) || (k == 4);
      expData  = (k == 1) ? DATA_A : (k == 3) ? DATA_B : 82'd0;
      checkOutput("b2b.valid", 128'(respValidA), 128'(expValid));
      if (expValid) checkOutput("b2b.data", 128'(rdataA), 128'(expData));
      if (c < 5) applyStimulus(b2bWm[c], b2bAddr[c], b2bData[c], 2'b11);
      else idle();
      @(negedge clock);
    end
    idle();

    doWrite(10'd1010, ONES, 2'b11);
    doRead("oor1010", 10'd1010, ONES, 1'b1, '0);
    doWrite(10'd999, DATA_C, 2'b11);
    doRead("last999", 10'd999, DATA_C, 1'b1, DATA_C);

    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst2.ready", 128'(readyA), 128'd0);
    reset = 1'b0;
    repeat (500) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    waitInit("init2", 1'b0);

    doWrite(10'd7, DATA_C, 2'b11);
    applyStimulus(1'b0, 10'd7, '0, '0);
    @(negedge clock);
    idle();
    reset = 1'b1;
    @(negedge clock);
    checkOutput("kill.validA", 128'(respValidA), 128'd0);
    checkOutput("kill.rdataA", 128'(rdataA), 128'd0);
    checkOutput("kill.validB", 128'(respValidB), 128'd0);
    checkOutput("kill.rdataB", 128'(rdataB), 128'd0);
    waitInit("init3", 1'b0);
    doRead("clr7", 10'd7, '0, 1'b1, '0);
    doRead("clr3", 10'd3, '0, 1'b1, '0);
    doRead("clr999", 10'd999, '0, 1'b1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
